// File: rtl/bias_pkg.sv
// Shared types and defaults for the per-lane bias stream loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bias_pkg;

    localparam int BIAS_W        = 18;   // bias word width, two's complement fixed-point
    localparam int N_LANES_DEF   = 16;   // default number of adder-tree lanes

    typedef logic signed [BIAS_W-1:0] bias_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bias_bank.sv
// Lane-addressed register bank of N_adder_tree x DATA_W words with a bulk-load port.
// Latency: a write or bulk load is visible on q the cycle after the edge that samples it.
// Backpressure: none; always accepts. A bulk load takes priority over a lane write.
//
// Ports:
//   clk, rst_n      clock, async active-low reset (clears every lane to zero)
//   wr_en/wr_lane   single-lane write of wr_data into lane wr_lane
//   ld_en/ld_data   load all lanes at once from a flat vector (lane i at [DATA_W*i +: DATA_W])
//   q               flat view of the bank, same layout as ld_data
module bias_bank
    import bias_pkg::*;
#(
    parameter int N_adder_tree = N_LANES_DEF,
    parameter int DATA_W       = BIAS_W,
    parameter int LANE_W       = $clog2(N_adder_tree)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [LANE_W-1:0]              wr_lane,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           ld_en,
    input  logic [N_adder_tree*DATA_W-1:0] ld_data,
    output logic [N_adder_tree*DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [N_adder_tree];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_adder_tree; i++) begin
                mem[i] <= '0;
            end
        end else if (ld_en) begin
            for (int i = 0; i < N_adder_tree; i++) begin
                mem[i] <= ld_data[i*DATA_W +: DATA_W];
            end
        end else if (wr_en) begin
            mem[wr_lane] <= wr_data;
        end
    end

    for (genvar g = 0; g < N_adder_tree; g++) begin : g_flat
        assign q[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/bias_stream_loader.sv
// Streams a per-lane bias vector into a shadow bank, then commits it to the active bank driving q.
// Latency: last word at t -> load_done at t+1; swap_req at s -> q at s+1 (auto-swap: q at t+2).
// Backpressure: s_ready drops only while a complete shadow vector waits for its swap (FULL).
//
// Optional feature macro: BIAS_LOADER_AUTO_SWAP_EN -- commit automatically after the last word,
// load_done becomes a one-cycle pulse and swap_req is ignored.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   s_valid/s_ready/s_data     bias word stream, lane 0 first
//   s_last                     final word of a vector; must land on lane N_adder_tree-1
//   swap_req                   pulse in FULL to commit shadow -> active
//   q                          active vector, lane i at q[DATA_W*(i+1)-1 : DATA_W*i]
//   q_valid                    active bank has been committed at least once since reset
//   load_done                  shadow vector complete, awaiting commit
//   err / err_clr              sticky framing error and its clear (set wins)
module bias_stream_loader
    import bias_pkg::*;
#(
    parameter int N_adder_tree = N_LANES_DEF,
    parameter int DATA_W       = BIAS_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W-1:0]              s_data,
    input  logic                           s_last,
    input  logic                           swap_req,
    output logic [N_adder_tree*DATA_W-1:0] q,
    output logic                           q_valid,
    output logic                           load_done,
    output logic                           err,
    input  logic                           err_clr
);

    localparam int                LANE_W    = $clog2(N_adder_tree);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_adder_tree - 1);

    loader_state_t               state_q, state_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic                        err_q, err_d;
    logic                        qv_q, qv_d;
    logic                        frame_err;
    logic                        ld_en;
    logic                        xfer;
    logic [N_adder_tree*DATA_W-1:0] shadow_q;

    assign xfer = s_valid && s_ready;

`ifdef BIAS_LOADER_AUTO_SWAP_EN
    // Commit is deferred one edge after the last word so the copy reads the
    // shadow bank with that word already written.
    logic pend_q, pend_d;
    logic unused_swap_req;

    assign unused_swap_req = swap_req;
    assign load_done       = pend_q;
`else
    assign load_done = (state_q == FULL);
`endif

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        frame_err = 1'b0;
        ld_en     = 1'b0;
        s_ready   = 1'b1;
`ifdef BIAS_LOADER_AUTO_SWAP_EN
        pend_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // The lane counter is always 0 here; a vector is at least two
                // words long, so s_last on the first word is always early.
                if (xfer) begin
                    if (s_last) begin
                        frame_err = 1'b1;
                    end else begin
                        lane_d  = LANE_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (s_last != (lane_q == LAST_LANE)) begin
                        frame_err = 1'b1;
                        lane_d    = '0;
                        state_d   = IDLE;
                    end else if (s_last) begin
                        lane_d  = '0;
`ifdef BIAS_LOADER_AUTO_SWAP_EN
                        pend_d  = 1'b1;
                        state_d = IDLE;
`else
                        state_d = FULL;
`endif
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            FULL: begin
                s_ready = 1'b0;
`ifdef BIAS_LOADER_AUTO_SWAP_EN
                state_d = IDLE;
`else
                if (swap_req) begin
                    ld_en   = 1'b1;
                    lane_d  = '0;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
`ifdef BIAS_LOADER_AUTO_SWAP_EN
        ld_en = pend_q;
`endif
    end

    // Set has priority over clear so a coincident error is never lost.
    assign err_d = frame_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
    assign qv_d  = qv_q | ld_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            err_q   <= 1'b0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            qv_q    <= qv_d;
        end
    end

`ifdef BIAS_LOADER_AUTO_SWAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign err     = err_q;
    assign q_valid = qv_q;

    bias_bank #(
        .N_adder_tree (N_adder_tree),
        .DATA_W       (DATA_W),
        .LANE_W       (LANE_W)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (xfer),
        .wr_lane (lane_q),
        .wr_data (s_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .q       (shadow_q)
    );

    // q comes straight from the active flops; the stream never reaches it directly.
    bias_bank #(
        .N_adder_tree (N_adder_tree),
        .DATA_W       (DATA_W),
        .LANE_W       (LANE_W)
    ) u_active (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (1'b0),
        .wr_lane ('0),
        .wr_data ('0),
        .ld_en   (ld_en),
        .ld_data (shadow_q),
        .q       (q)
    );

endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed bench for bias_stream_loader with a scoreboard of committed vectors.
// Latency: checks load_done at t+1 and q at s+1 (auto-swap build: q at t+2).
// Backpressure: exercises s_ready low in FULL with s_valid held.
module tb_bias_stream_loader;

    localparam int N = 16;
    localparam int W = 18;
    typedef logic [N*W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          swap_req = 1'b0;
    vec_t          q;
    logic          q_valid;
    logic          load_done;
    logic          err;
    logic          err_clr = 1'b0;

    int   tests = 0;
    int   fails = 0;
    vec_t exp_q[$];
    vec_t committed = '0;
    vec_t va, vb, vc, vd, ve;

    bias_stream_loader #(.N_adder_tree(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .swap_req  (swap_req),
        .q         (q),
        .q_valid   (q_valid),
        .load_done (load_done),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chkv(input string tag, input vec_t obs, input vec_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // One word per call; returns 1 ns after the edge that samples it.
    task automatic send(input logic [W-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Full clean vector; the expected commit is queued as it is driven.
    task automatic load_vec(input vec_t v, input bit gaps, input bit swap_on_last);
        exp_q.push_back(v);
        for (int i = 0; i < N; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                @(posedge clk);
                #1;
            end
            if (swap_on_last && i == N - 1) swap_req = 1'b1;
            send(v[i*W +: W], i == N - 1);
            if (swap_on_last) swap_req = 1'b0;
            chkv("q_stable_during_load", q, committed);
        end
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        @(posedge clk);
        #1;
        swap_req = 1'b0;
        committed = exp_q.pop_front();
        chkv("q_after_swap", q, committed);
        chk1("q_valid_after_swap", q_valid, 1'b1);
        chk1("load_done_after_swap", load_done, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chkv({tag, "_q"}, q, '0);
        chk1({tag, "_q_valid"}, q_valid, 1'b0);
        chk1({tag, "_load_done"}, load_done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_s_ready"}, s_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) va[i*W +: W] = W'(i + 1);
        vb = rand_vec();
        vc = rand_vec();
        vd = rand_vec();
        ve = rand_vec();

        #2 rst_n = 1'b0;
        #1 reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef BIAS_LOADER_AUTO_SWAP_EN
        // swap_req held high throughout: it must never cause a commit.
        swap_req = 1'b1;
        load_vec(va, 1'b1, 1'b0);
        chk1("auto_load_done_pulse", load_done, 1'b1);
        chkv("auto_q_not_yet", q, committed);
        chk1("auto_q_valid_not_yet", q_valid, 1'b0);
        @(posedge clk);
        #1;
        committed = exp_q.pop_front();
        chkv("auto_q_t2", q, committed);
        chk1("auto_q_valid", q_valid, 1'b1);
        chk1("auto_load_done_drop", load_done, 1'b0);
        load_vec(vb, 1'b1, 1'b0);
        chk1("auto_load_done_pulse_b", load_done, 1'b1);
        chkv("auto_q_still_a", q, committed);
        @(posedge clk);
        #1;
        committed = exp_q.pop_front();
        chkv("auto_q_b", q, committed);
        chk1("auto_load_done_drop_b", load_done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chkv("auto_swap_idle_ignored", q, committed);
        chk1("auto_err", err, 1'b0);
        swap_req = 1'b0;
`else
        // Basic load: lane i = i+1, commit on swap.
        load_vec(va, 1'b0, 1'b0);
        chk1("load_done_t1", load_done, 1'b1);
        chk1("s_ready_full", s_ready, 1'b0);
        chk1("q_valid_before_swap", q_valid, 1'b0);
        do_swap();
        chk1("err_clean", err, 1'b0);
        chk1("s_ready_idle", s_ready, 1'b1);

        // swap in IDLE is ignored.
        swap_req = 1'b1;
        @(posedge clk);
        #1;
        swap_req = 1'b0;
        chkv("swap_idle_ignored", q, committed);

        // Early s_last on word 5.
        for (int i = 0; i < 5; i++) send(W'(i + 100), i == 4);
        chk1("early_err", err, 1'b1);
        chk1("early_s_ready", s_ready, 1'b1);
        chkv("early_q_kept", q, committed);
        chk1("early_q_valid", q_valid, 1'b1);
        chk1("early_load_done", load_done, 1'b0);
        load_vec(vc, 1'b0, 1'b0);
        do_swap();
        chk1("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk1("err_cleared", err, 1'b0);

        // Missing s_last on the final lane.
        for (int i = 0; i < N; i++) send(W'(i + 200), 1'b0);
        chk1("missing_err", err, 1'b1);
        chk1("missing_load_done", load_done, 1'b0);
        chkv("missing_q_kept", q, committed);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk1("err_cleared2", err, 1'b0);

        // FULL ignores the stream.
        load_vec(vd, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 18'h3FFFF;
        s_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk1("full_s_ready_low", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        do_swap();

        // Swap coinciding with the last word is ignored; a later pulse commits.
        load_vec(vb, 1'b0, 1'b1);
        chk1("same_edge_swap_load_done", load_done, 1'b1);
        chkv("same_edge_swap_q_kept", q, committed);
        repeat (2) @(posedge clk);
        #1;
        chkv("full_wait_q_kept", q, committed);
        do_swap();

        // Error with coincident err_clr: set wins.
        err_clr = 1'b1;
        send(W'(7), 1'b1);
        err_clr = 1'b0;
        chk1("err_set_wins", err, 1'b1);

        // Async reset in the middle of a load, lane counter at 7.
        for (int i = 0; i < 7; i++) send(W'(i + 300), 1'b0);
        #2 rst_n = 1'b0;
        #1 reset_checks("midreset");
        committed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_vec(ve, 1'b0, 1'b0);
        chk1("post_reset_load_done", load_done, 1'b1);
        do_swap();
`endif

        chk1("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bias_stream_loader.md
Name: bias_stream_loader

Overview:
- Runtime writer for a layer's per-lane bias vector.
- Accepts 18-bit two's-complement bias words over a valid/ready stream and fills a shadow register bank, lane 0 first.
- Presents the committed vector on a flat bus `q[N_adder_tree*18-1:0]`, lane i at `q[18*(i+1)-1:18*i]`. This is the layout the adder-tree bias inputs already consume.
- Replaces hard-wired bias constants when weights/biases are reloaded per layer.

Parameters:
- N_adder_tree, 16, number of bias lanes (one per adder tree); legal range 2..64
- DATA_W, 18, bias word width (fixed-point, two's complement)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  loader can accept a word this cycle
- s_data  in  DATA_W  bias word for the current lane
- s_last  in  1  marks the final word of a vector (must coincide with lane N_adder_tree-1)
- swap_req  in  1  single-cycle pulse: commit the shadow bank to the active bank
- q  out  N_adder_tree*DATA_W  active bias vector
- q_valid  out  1  active bank holds a committed vector
- load_done  out  1  shadow bank is complete and awaiting swap
- err  out  1  sticky framing-error flag
- err_clr  in  1  clears err

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset tree):
  - shadow and active banks = 0, q = 0, q_valid = 0, load_done = 0, err = 0
  - lane counter = 0, state = IDLE
- A word transfers when s_valid && s_ready on a rising clk edge. The word is written to shadow[lane] and lane increments.
- FSM states:
  - IDLE: s_ready = 1.
    - A transfer writes lane 0 and moves to LOAD.
    - If N_adder_tree words would be needed but s_last arrives on lane 0, apply the error rule below.
  - LOAD: s_ready = 1.
    - A transfer on lane N_adder_tree-1 with s_last = 1 → FULL; load_done = 1 from the next cycle.
    - s_last = 1 on lane < N_adder_tree-1 (early), or s_last = 0 on lane N_adder_tree-1 (missing): set err, reset lane to 0, go to IDLE. The shadow contents are don't-care; the active bank is untouched.
  - FULL: s_ready = 0, load_done = 1.
    - swap_req → copy shadow to active in one cycle. q updates and q_valid = 1 on the cycle after swap_req is sampled.
    - Same edge: load_done = 0, lane = 0, state = IDLE.
- swap_req in IDLE or LOAD is ignored; the active bank and q_valid are unchanged.
- swap_req on the same edge as the final word's transfer is ignored, because the state is still LOAD. The swap requires a pulse while in FULL.
- q is combinationally driven from active-bank flops only; no path from s_data to q.
- Once set, q_valid stays 1 until reset. A subsequent load never disturbs q until the next swap, so the adder trees see a stable bias throughout.
- err: set on a framing error and held. err_clr clears it next cycle; if err_clr coincides with a new error, set wins.
- Reset mid-load: all state returns to reset values; a partial vector is discarded.
- Latency: final word accepted at cycle t → load_done at t+1. swap_req sampled at cycle s → new q at s+1.
- No arithmetic is performed on bias words; they are stored bit-exact.

Optional Feature:
- Macro: BIAS_LOADER_AUTO_SWAP_EN.
- Defined: the FULL state is skipped. The final valid word triggers the shadow→active copy on the following edge (q updates at t+2, q_valid = 1), load_done pulses for one cycle, and swap_req is ignored.
- Undefined: the explicit swap_req handshake described above.

Decomposition:
- Shared package bias_pkg:
  - localparam BIAS_W = 18
  - default lane count 16
  - typedef bias_t (logic signed [BIAS_W-1:0])
  - enum loader_state_t {IDLE, LOAD, FULL}
- One sub-module, bias_bank: N_adder_tree × DATA_W register array with
  - per-lane write enable (shadow writes)
  - bulk-load port (active copy)
  - async active-low reset to zero
- Instantiated twice, as shadow and active.

Test Plan:
- Reset, then stream 16 words 0x00001..0x00010 with s_last on word 16, swap_req → load_done after word 16; q lane i = i+1 the cycle after swap; q_valid = 1; err = 0.
- s_last asserted on word 5 → err = 1; s_ready stays 1; q and q_valid unchanged; a following clean 16-word load plus swap succeeds; err_clr drops err.
- In FULL, hold s_valid = 1 with data 0x3FFFF for 10 cycles → s_ready = 0, no writes; after swap, q matches the pre-FULL vector, not 0x3FFFF.
- Commit vector A, then load vector B without swapping → q still equals A for the entire load; swap → q = B next cycle.
- Assert rst_n = 0 asynchronously mid-load at lane 7 → all outputs 0 immediately; after release, a full load starting at lane 0 works.
- With BIAS_LOADER_AUTO_SWAP_EN: a 16-word load with s_valid throttled by 50% random gaps → q updates 2 cycles after the last word; load_done is a single-cycle pulse; swap_req has no effect.
